// File: rtl/his_builder_pingpong.sv
// Ping-pong dToF histogram builder: one bank accumulates TDC hits while the other
// holds the last completed histogram for random-access readout.
module his_builder_pingpong #(
  parameter int ADDR_W        = 6,
  parameter int CNT_W         = 8,
  parameter int HITS_PER_SHOT = 2,
  parameter int SHOTS         = 1000,
  parameter int DROP_W        = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              hisNum,
  output logic              his_valid,
  output logic              his_done,
  output logic              busy_clr,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int NBINS  = 2 ** ADDR_W;
  localparam int HIT_W  = (HITS_PER_SHOT > 1) ? $clog2(HITS_PER_SHOT) : 1;
  localparam int SHOT_W = (SHOTS > 1) ? $clog2(SHOTS) : 1;
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(HITS_PER_SHOT - 1);
  localparam logic [SHOT_W-1:0] SHOT_LAST = SHOT_W'(SHOTS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;
  localparam logic [ADDR_W-1:0] CLR_LAST  = '1;

  typedef enum logic [1:0] {CLEAR, ACCUM, SWAP} state_t;

  state_t              state_q;
  logic [HIT_W-1:0]    hit_cnt_q;
  logic [SHOT_W-1:0]   shot_cnt_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic                hisnum_q;
  logic                his_valid_q;
  logic                his_done_q;
  logic [DROP_W-1:0]   drop_q;
  logic [CNT_W-1:0]    rd_data_q;
  logic                rd_valid_q;

  // Read stage of the read-modify-write pipeline, plus the write just committed
  logic                p1_valid_q;
  logic [ADDR_W-1:0]   p1_addr_q;
  logic [CNT_W-1:0]    p1_rdata_q;
  logic                fw_valid_q;
  logic [ADDR_W-1:0]   fw_addr_q;
  logic [CNT_W-1:0]    fw_data_q;

  // Both banks in one array; MSB of the index selects the bank
  logic [CNT_W-1:0]    mem_q [2*NBINS];

  logic                hit_acc;
  logic [CNT_W-1:0]    old_cnt_d;
  logic [CNT_W-1:0]    new_cnt_d;
  logic                mem_we_d;
  logic [ADDR_W:0]     mem_waddr_d;
  logic [CNT_W-1:0]    mem_wdata_d;

  assign hit_acc = wrEn && (state_q == ACCUM);

  always_comb begin
    // The read at the same edge as the previous write sees the stale value
    old_cnt_d   = (fw_valid_q && (fw_addr_q == p1_addr_q)) ? fw_data_q : p1_rdata_q;
    new_cnt_d   = (old_cnt_d == CNT_MAX) ? CNT_MAX : old_cnt_d + 1'b1;
    mem_we_d    = 1'b0;
    mem_waddr_d = {~hisnum_q, p1_addr_q};
    mem_wdata_d = new_cnt_d;
    if (p1_valid_q) begin
      mem_we_d = 1'b1;
    end else if (state_q == CLEAR) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = {~hisnum_q, clr_addr_q};
      mem_wdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
    p1_rdata_q <= mem_q[{~hisnum_q, addr}];
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= CLEAR;
      hit_cnt_q   <= '0;
      shot_cnt_q  <= '0;
      clr_addr_q  <= '0;
      hisnum_q    <= 1'b0;
      his_valid_q <= 1'b0;
      his_done_q  <= 1'b0;
      drop_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_addr_q   <= '0;
      fw_valid_q  <= 1'b0;
      fw_addr_q   <= '0;
      fw_data_q   <= '0;
    end else begin
      his_done_q <= 1'b0;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem_q[{hisnum_q, rd_addr}];
      end
      p1_valid_q <= hit_acc;
      p1_addr_q  <= addr;
      fw_valid_q <= p1_valid_q;
      fw_addr_q  <= p1_addr_q;
      fw_data_q  <= new_cnt_d;
      if (wrEn && (state_q != ACCUM) && (drop_q != DROP_MAX)) begin
        drop_q <= drop_q + 1'b1;
      end
      case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == CLR_LAST) begin
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (wrEn) begin
            if (hit_cnt_q == HIT_LAST) begin
              hit_cnt_q <= '0;
              if (shot_cnt_q == SHOT_LAST) begin
                shot_cnt_q <= '0;
                state_q    <= SWAP;
              end else begin
                shot_cnt_q <= shot_cnt_q + 1'b1;
              end
            end else begin
              hit_cnt_q <= hit_cnt_q + 1'b1;
            end
          end
        end
        SWAP: begin
          // Last hit commits to the old write bank on this same edge
          hisnum_q    <= ~hisnum_q;
          his_done_q  <= 1'b1;
          his_valid_q <= 1'b1;
          state_q     <= CLEAR;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign hisNum    = hisnum_q;
  assign his_valid = his_valid_q;
  assign his_done  = his_done_q;
  assign busy_clr  = (state_q == CLEAR);
  assign drop_cnt  = drop_q;

endmodule

// File: doc/his_builder_pingpong.md
Name: his_builder_pingpong

Overview:
- Parametrised successor to the single-bank dToF histogram builder.
- Accumulates TDC hit addresses into per-bin counters in one bank (write bank) while the other bank (read bank) holds the last completed histogram for the downstream peak/data-formatting logic.
- Nested hit/shot counters define histogram completion. On completion the banks swap and the new write bank is cleared sequentially.
- Adds saturating bins, same-bin read-modify-write forwarding, a dropped-hit counter and a random-access read port.

Parameters:
- ADDR_W, 6, bin address width; NBINS = 2**ADDR_W
- CNT_W, 8, bin counter width; saturates at 2**CNT_W-1
- HITS_PER_SHOT, 2, accepted hits that close one shot (>=1)
- SHOTS, 1000, shots per histogram (>=1)
- DROP_W, 16, dropped-hit counter width

Ports:
- clk  in  1  clock
- res  in  1  asynchronous active-low reset
- wrEn  in  1  hit strobe, one hit per cycle
- addr  in  ADDR_W  bin index of hit
- rd_en  in  1  read request on read bank
- rd_addr  in  ADDR_W  read bin index
- rd_data  out  CNT_W  bin count, valid when rd_valid=1
- rd_valid  out  1  asserted 1 cycle after rd_en
- hisNum  out  1  index of read bank; write bank = ~hisNum
- his_valid  out  1  read bank holds a completed histogram
- his_done  out  1  one-cycle pulse at bank swap
- busy_clr  out  1  high while the write bank is being cleared
- drop_cnt  out  DROP_W  saturating count of wrEn pulses ignored

Behaviour:
- Clock is clk. Reset res is asynchronous and active-low.
- Reset values: rd_data=0, rd_valid=0, hisNum=0, his_valid=0, his_done=0, drop_cnt=0, hit/shot counters=0, state=CLEAR, clr_addr=0. busy_clr=1 follows state. Reset mid-operation abandons the partial histogram.
- FSM states: CLEAR, ACCUM, SWAP.
- CLEAR: writes 0 to write-bank bin clr_addr each cycle, for NBINS cycles (0..NBINS-1). After the write at NBINS-1, goes to ACCUM. busy_clr=1 only in CLEAR. wrEn in CLEAR is dropped and drop_cnt increments.
- ACCUM, per wrEn:
  - bin[addr] <= min(bin[addr]+1, 2**CNT_W-1).
  - hit_cnt increments; at HITS_PER_SHOT-1 it wraps to 0 and shot_cnt increments.
  - The hit that completes shot SHOTS-1 moves the FSM to SWAP next cycle; shot_cnt returns to 0.
- RMW pipeline: 2 stages (read at edge N, write at N+1). Back-to-back or interleaved hits to the same bin must all be counted, using forwarding from the pending write. No hit is lost at any sustained rate of 1 hit/cycle.
- SWAP: lasts 1 cycle; the last hit's write has committed before exit. wrEn in SWAP is dropped (drop_cnt++). On exit edge, in the same cycle:
  - hisNum toggles;
  - his_done=1 for exactly that one cycle;
  - his_valid=1, held until reset;
  - FSM goes to CLEAR on the new write bank.
- Read port:
  - rd_en sampled at edge E reads bank hisNum as valued before E.
  - rd_data/rd_valid appear after E and remain for one cycle. rd_data holds its last value otherwise; rd_valid=0 otherwise.
  - A read in the his_done cycle is sampled at the next edge and returns the newly completed bank.
  - Reads never disturb the write bank.
  - Reads with his_valid=0 return undefined-but-stable data; the bench must not check them.
- drop_cnt saturates at 2**DROP_W-1 and does not wrap.
- Counter widths: hit_cnt uses clog2(HITS_PER_SHOT) bits, minimum 1. shot_cnt uses clog2(SHOTS) bits, minimum 1.
- Bins not hit in a histogram read 0.

Test Plan:
- Reset, defaults: release res → busy_clr=1 for exactly 64 cycles, hisNum=0, his_valid=0. Three wrEn pulses during clear → drop_cnt=3, then busy_clr=0.
- SHOTS=4, HITS_PER_SHOT=2: 8 consecutive wrEn at addr=5 after clear → his_done pulses once 2 cycles after the 8th hit, hisNum=1, his_valid=1. Reads: bin5=8, bins 0–4 and 6–63=0, rd_valid 1 cycle after rd_en.
- Forwarding, same config: back-to-back addr sequence 1,1,2,1,1,1,7,1 → read bin1=6, bin2=1, bin7=1.
- Saturation, CNT_W=4, SHOTS=20, HITS_PER_SHOT=1: 20 hits to addr 9 → bin9=15.
- Ping-pong: after the first swap (bin5=8), send 8 hits to addr 3. While accumulating, bin5 still reads 8. After the second his_done: hisNum=0, bin3=8, bin5=0 (cleared bank). A hit during SWAP → drop_cnt+1.
- Reset mid-ACCUM: after 3 of 8 hits, pulse res low → all outputs at reset values. A full 8 new hits to addr 0 → bin0=8, with no residue from the aborted hits.
